// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl -- central pipeline controller.
//
// Drives the IF/ID, ID/EX, EX/MEM and MEM/WB latch commands, the PC enable
// and the registered CPU halt. It resolves four hazard classes: data-memory
// wait, control redirect, load-use and fetch miss.
//
// Optional build macro: PIPE_PERF_EN adds the stall/flush performance
// counters. Without it, both counter ports are tied to zero.
//
// Ports:
//   CLK, nRST            clock and asynchronous active-low reset
//   ihit, dhit           fetch / data access completed this cycle
//   m_dREN, m_dWEN       MEM stage holds a load / store
//   m_redirect           MEM stage resolved a taken branch or jump
//   e_MemRead            EX stage holds a load
//   e_regWSEL            EX stage destination register
//   d_rs, d_rt           ID stage source registers
//   w_halt               halt has reached WB
//   fd/de/em/mw_state    latch commands (cpu_types_pkg encodings)
//   pc_en                PC update enable
//   halt                 registered CPU halt
//   stall_cycles         cycles with pc_en=0 outside HALTED (PIPE_PERF_EN)
//   flush_count          applied redirects (PIPE_PERF_EN)

package cpu_types_pkg;
  typedef enum logic [1:0] {
    PIPE_ENABLE = 2'b00,
    PIPE_STALL  = 2'b01,
    PIPE_NOP    = 2'b10
  } pipe_state_t;
endpackage

module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             m_dREN,
  input  logic             m_dWEN,
  input  logic             m_redirect,
  input  logic             e_MemRead,
  input  logic [REG_W-1:0] e_regWSEL,
  input  logic [REG_W-1:0] d_rs,
  input  logic [REG_W-1:0] d_rt,
  input  logic             w_halt,
  output logic [1:0]       fd_state,
  output logic [1:0]       de_state,
  output logic [1:0]       em_state,
  output logic [1:0]       mw_state,
  output logic             pc_en,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED} fsm_t;

  fsm_t        state, next_state;
  pipe_state_t fd, de, em, mw;
  logic        mem_req, load_use, resolve;
`ifdef PIPE_PERF_EN
  logic        redirect_taken;
`endif

  assign mem_req  = m_dREN | m_dWEN;
  assign load_use = e_MemRead && (e_regWSEL != '0) &&
                    ((e_regWSEL == d_rs) || (e_regWSEL == d_rt));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
      halt  <= 1'b0;
    end else begin
      state <= next_state;
      halt  <= (next_state == HALTED);
    end
  end

  // RUN and MEM_WAIT (on dhit) share rules 3-6, so the case only decides
  // whether to freeze or to fall through to the common resolution below.
  always_comb begin
    fd         = PIPE_STALL;
    de         = PIPE_STALL;
    em         = PIPE_STALL;
    mw         = PIPE_STALL;
    pc_en      = 1'b0;
    next_state = state;
    resolve    = 1'b0;
`ifdef PIPE_PERF_EN
    redirect_taken = 1'b0;
`endif

    unique case (state)
      RUN: begin
        if (w_halt)               next_state = HALTED;
        else if (mem_req && !dhit) next_state = MEM_WAIT;
        else                       resolve    = 1'b1;
      end
      MEM_WAIT: begin
        if (dhit) begin
          resolve    = 1'b1;
          next_state = RUN;
        end
      end
      HALTED: ;
      default: next_state = RUN;
    endcase

    if (resolve) begin
      if (m_redirect) begin
        fd    = PIPE_NOP;
        de    = PIPE_NOP;
        em    = PIPE_NOP;
        mw    = PIPE_ENABLE;
        pc_en = 1'b1;
`ifdef PIPE_PERF_EN
        redirect_taken = 1'b1;
`endif
      end else if (load_use) begin
        fd = PIPE_STALL;
        de = PIPE_NOP;
        em = PIPE_ENABLE;
        mw = PIPE_ENABLE;
      end else if (!ihit) begin
        fd = PIPE_NOP;
        de = PIPE_ENABLE;
        em = PIPE_ENABLE;
        mw = PIPE_ENABLE;
      end else begin
        fd    = PIPE_ENABLE;
        de    = PIPE_ENABLE;
        em    = PIPE_ENABLE;
        mw    = PIPE_ENABLE;
        pc_en = 1'b1;
      end
    end

    // Reset forces bubbles into every latch regardless of the FSM.
    if (!nRST) begin
      fd    = PIPE_NOP;
      de    = PIPE_NOP;
      em    = PIPE_NOP;
      mw    = PIPE_NOP;
      pc_en = 1'b0;
    end
  end

  assign fd_state = fd;
  assign de_state = de;
  assign em_state = em;
  assign mw_state = mw;

`ifdef PIPE_PERF_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_en && state != HALTED) stall_cycles <= stall_cycles + 1'b1;
      if (redirect_taken)            flush_count  <= flush_count + 1'b1;
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central pipeline controller. Generates the per-latch state commands (fd/de/em/mw) that the IF/ID, ID/EX, EX/MEM and MEM/WB latches consume, plus the PC enable and the registered CPU halt.
- Resolves four hazard classes: data-memory wait, load-use, control redirect, and fetch miss.
- Sits beside the datapath and is the single source of every `*_state` input the pipeline latches sample.

Parameters:
- REG_W, 5, register-select width.
- CNT_W, 32, width of the performance counters (used only with PIPE_PERF_EN).

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  instruction fetch completed this cycle.
- dhit  in  1  data access completed this cycle.
- m_dREN  in  1  MEM stage holds a load.
- m_dWEN  in  1  MEM stage holds a store.
- m_redirect  in  1  MEM stage resolved a taken branch or jump; PC loads the target.
- e_MemRead  in  1  EX stage holds a load.
- e_regWSEL  in  REG_W  EX stage destination register.
- d_rs  in  REG_W  ID stage source register rs.
- d_rt  in  REG_W  ID stage source register rt.
- w_halt  in  1  halt has reached WB.
- fd_state  out  2  IF/ID latch command.
- de_state  out  2  ID/EX latch command.
- em_state  out  2  EX/MEM latch command.
- mw_state  out  2  MEM/WB latch command.
- pc_en  out  1  PC register update enable.
- halt  out  1  registered CPU halt.
- stall_cycles  out  CNT_W  count of cycles with pc_en=0 and not halted.
- flush_count  out  CNT_W  count of redirects.

Behaviour:
- State encodings come from cpu_types_pkg: PIPE_ENABLE (latch loads), PIPE_STALL (latch holds), PIPE_NOP (latch loads a bubble).
- Reset is asynchronous on nRST, active-low; clock is CLK.
- FSM states: RUN, MEM_WAIT, HALTED. Reset enters RUN.
- Reset values: halt=0, counters=0. While nRST=0, all four state outputs are PIPE_NOP and pc_en=0.
- Output decode is Mealy: state register plus current inputs. Only halt and the counters are registered.
- RUN, priority order (first match wins):
  1. w_halt=1: all four states STALL, pc_en=0. Next state HALTED; halt=1 from the next edge.
  2. (m_dREN|m_dWEN)=1 and dhit=0: all four states STALL, pc_en=0. Next state MEM_WAIT.
  3. m_redirect=1: fd/de/em NOP, mw ENABLE, pc_en=1. flush_count increments.
  4. Load-use (e_MemRead=1, e_regWSEL!=0, and e_regWSEL equals d_rs or d_rt): fd STALL, de NOP, em/mw ENABLE, pc_en=0.
  5. ihit=0: fd NOP, de/em/mw ENABLE, pc_en=0.
  6. Otherwise: all four states ENABLE, pc_en=1.
- A memory request with dhit=1 in the same cycle causes no wait; evaluation continues at rule 3.
- MEM_WAIT:
  - dhit=0: all four states STALL, pc_en=0; remain in MEM_WAIT.
  - dhit=1: re-evaluate RUN rules 3–6 in this cycle, then go to RUN.
  - w_halt has no effect in MEM_WAIT, since WB is frozen.
- HALTED: all four states STALL, pc_en=0, halt=1. HALTED is sticky; only nRST exits it.
- Register $0 (e_regWSEL=0) never triggers load-use.
- m_redirect and a memory request in the same cycle: the memory wait wins, and the redirect is applied in the cycle dhit arrives.
- Reset asserted mid-wait: FSM returns to RUN immediately and halt clears asynchronously.

Optional Feature:
- Macro: PIPE_PERF_EN.
- Defined:
  - stall_cycles increments every cycle with pc_en=0 in RUN or MEM_WAIT.
  - flush_count increments on every applied redirect.
  - Both counters wrap modulo 2^CNT_W.
- Undefined: counter logic is omitted and both ports are tied to 0.

Test Plan:
- Reset pulse while m_dREN=1 and dhit=0 → during reset all four states PIPE_NOP and pc_en=0. After release with ihit=1 and no hazards: all four states PIPE_ENABLE, pc_en=1, halt=0.
- m_dREN=1 with dhit low for 3 cycles then high → 3 cycles of all-STALL with pc_en=0; on the dhit cycle all four states ENABLE; stall_cycles=3 (macro on).
- e_MemRead=1, e_regWSEL=8, d_rt=8, ihit=1 → fd STALL, de NOP, em ENABLE, mw ENABLE, pc_en=0. Repeat with e_regWSEL=0 and d_rs=0 → all four states ENABLE.
- m_redirect=1 together with the load-use condition → fd/de/em NOP, mw ENABLE, pc_en=1, flush_count=1.
- m_dWEN=1, dhit=0, m_redirect=1, then dhit=1 next cycle → first cycle all-STALL; second cycle the redirect pattern is applied.
- w_halt=1 → next edge halt=1 and all four states STALL. Then toggle ihit and dhit for 10 cycles → outputs unchanged until nRST is asserted.
